// File: rtl/day01_rotation_parser.sv
// Day01 rotation-list parser: walks the byte ROM, turns "L68\n"-style lines into
// (dir, magnitude) tokens on a valid/ready stream, and flags end of input or bad format.
module day01_rotation_parser #(
    parameter int N_ADDR_BITS = 16,
    parameter int VALUE_W     = 16,
    parameter int COUNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [N_ADDR_BITS:0] rom_addr,
    input  logic [7:0]           rom_data,
    input  logic                 rom_valid,
    output logic                 tok_valid,
    input  logic                 tok_ready,
    output logic                 tok_dir,
    output logic [VALUE_W-1:0]   tok_value,
    output logic                 tok_sat,
    output logic [COUNT_W-1:0]   tok_count,
    output logic                 done,
    output logic                 err
);
    localparam logic [1:0] S_DIR  = 2'd0;
    localparam logic [1:0] S_NUM  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    logic [1:0]         state;
    logic [VALUE_W-1:0] acc;
    logic               acc_sat;
    logic               has_digit;
    logic               pending_end;
    logic               dir;

    logic               fetch;
    logic               at_end;
    logic               is_digit;
    logic [VALUE_W+3:0] acc_ext;
    logic               acc_ovf;

    assign fetch    = (state == S_DIR || state == S_NUM) && !pending_end;
    assign at_end   = pending_end || !rom_valid;
    assign is_digit = (rom_data >= 8'h30) && (rom_data <= 8'h39);
    // acc*10 + digit with 4 bits of headroom so overflow is visible
    assign acc_ext  = ({4'b0, acc} << 3) + ({4'b0, acc} << 1)
                    + {{VALUE_W{1'b0}}, rom_data[3:0]};
    assign acc_ovf  = |acc_ext[VALUE_W+3:VALUE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr    <= '0;
            tok_valid   <= 1'b0;
            tok_dir     <= 1'b0;
            tok_value   <= '0;
            tok_sat     <= 1'b0;
            tok_count   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            state       <= S_DIR;
            acc         <= '0;
            acc_sat     <= 1'b0;
            has_digit   <= 1'b0;
            pending_end <= 1'b0;
            dir         <= 1'b0;
        end else begin
            // Address parks at all-ones; the last byte then counts as end of input.
            if (fetch) begin
                if (&rom_addr) pending_end <= 1'b1;
                else           rom_addr    <= rom_addr + (N_ADDR_BITS+1)'(1);
            end
            case (state)
                S_DIR: begin
                    if (at_end) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (rom_data == CH_L || rom_data == CH_R) begin
                        dir       <= (rom_data == CH_R);
                        acc       <= '0;
                        acc_sat   <= 1'b0;
                        has_digit <= 1'b0;
                        state     <= S_NUM;
                    end else if (rom_data != CH_LF && rom_data != CH_CR) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_NUM: begin
                    if (at_end || rom_data == CH_LF) begin
                        if (has_digit) begin
                            tok_value <= acc;
                            tok_dir   <= dir;
                            tok_sat   <= acc_sat;
                            tok_valid <= 1'b1;
                            state     <= S_EMIT;
                            if (at_end) pending_end <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (is_digit) begin
                        acc       <= acc_ovf ? '1 : acc_ext[VALUE_W-1:0];
                        acc_sat   <= acc_sat | acc_ovf;
                        has_digit <= 1'b1;
                    end else if (rom_data != CH_CR) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_EMIT: begin
                    if (tok_ready) begin
                        tok_valid <= 1'b0;
                        if (~&tok_count) tok_count <= tok_count + COUNT_W'(1);
                        if (pending_end) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DIR;
                        end
                    end
                end
                default: begin
                    tok_valid <= 1'b0;
                    done      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_day01_rotation_parser.sv
// Bench for day01_rotation_parser: two instances (wide default and a narrow one with a
// 16-byte address space) fed from one byte memory, checked against a software parse.
module tb_day01_rotation_parser;
    typedef struct {
        bit dir;
        int value;
        bit sat;
    } tok_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tok_ready = 1'b1;

    logic [16:0] a_rom_addr;
    logic [7:0]  a_rom_data = 8'h00;
    logic        a_rom_valid;
    logic        a_tok_valid, a_tok_dir, a_tok_sat, a_done, a_err;
    logic [15:0] a_tok_value, a_tok_count;

    logic [3:0]  b_rom_addr;
    logic [7:0]  b_rom_data = 8'h00;
    logic        b_rom_valid;
    logic        b_tok_valid, b_tok_dir, b_tok_sat, b_done, b_err;
    logic [7:0]  b_tok_value;
    logic [15:0] b_tok_count;

    logic [7:0] mem [0:255];
    tok_t qa[$], qb[$], mq[$];
    bit   m_err;
    int   m_addr;
    int   wl;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    day01_rotation_parser #(.N_ADDR_BITS(16), .VALUE_W(16), .COUNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .rom_addr(a_rom_addr), .rom_data(a_rom_data),
        .rom_valid(a_rom_valid), .tok_valid(a_tok_valid), .tok_ready(tok_ready),
        .tok_dir(a_tok_dir), .tok_value(a_tok_value), .tok_sat(a_tok_sat),
        .tok_count(a_tok_count), .done(a_done), .err(a_err));

    day01_rotation_parser #(.N_ADDR_BITS(3), .VALUE_W(8), .COUNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
        .rom_valid(b_rom_valid), .tok_valid(b_tok_valid), .tok_ready(tok_ready),
        .tok_dir(b_tok_dir), .tok_value(b_tok_value), .tok_sat(b_tok_sat),
        .tok_count(b_tok_count), .done(b_done), .err(b_err));

    // ROM behaviour: byte for the current address appears on the negedge
    always @(negedge clk) begin
        a_rom_data <= (a_rom_addr < 17'd256) ? mem[a_rom_addr[7:0]] : 8'h00;
        b_rom_data <= mem[{4'h0, b_rom_addr}];
    end
    assign a_rom_valid = (a_rom_data != 8'h00);
    assign b_rom_valid = (b_rom_data != 8'h00);

    // tok_ready only changes just after posedge, so a negedge handshake is an acceptance
    always @(negedge clk) begin
        if (rst_n && a_tok_valid && tok_ready) qa.push_back('{a_tok_dir, int'(a_tok_value), a_tok_sat});
        if (rst_n && b_tok_valid && tok_ready) qb.push_back('{b_tok_dir, int'(b_tok_value), b_tok_sat});
    end

    task automatic load_str(input string s);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    endtask

    task automatic start();
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input int mode, output bit to);
        int cyc;
        cyc = 0;
        to = 1'b0;
        while (!(a_done && b_done)) begin
            tok_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
            if (cyc > 3000) begin to = 1'b1; break; end
        end
        tok_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Straight software parse of the byte stream as the rules describe it.
    task automatic model(input int vw, input int cap, input int amax);
        int i;
        longint v, mx;
        bit in_num, nd, sat, dir, stop;
        logic [7:0] c;
        mq.delete();
        m_err = 0; i = 0; in_num = 0; stop = 0; v = 0; nd = 0; sat = 0; dir = 0;
        mx = (64'd1 << vw) - 1;
        while (!stop) begin
            c = (i < cap) ? mem[i] : 8'h00;
            if (!in_num) begin
                if (c == 8'h00) stop = 1;
                else if (c == "L" || c == "R") begin
                    in_num = 1; dir = (c == "R"); v = 0; nd = 0; sat = 0;
                end else if (c != "\n" && c != "\r") begin
                    m_err = 1; stop = 1;
                end
            end else begin
                if (c >= "0" && c <= "9") begin
                    v = v * 10 + longint'(c - 8'h30);
                    if (v > mx) begin v = mx; sat = 1; end
                    nd = 1;
                end else if (c == "\r") begin
                end else if (c == "\n" || c == 8'h00) begin
                    if (!nd) begin m_err = 1; stop = 1; end
                    else begin
                        mq.push_back('{dir, int'(v), sat});
                        in_num = 0;
                        if (c == 8'h00) stop = 1;
                    end
                end else begin
                    m_err = 1; stop = 1;
                end
            end
            if (!stop) i++;
        end
        m_addr = (i + 1 > amax) ? amax : i + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({a_rom_addr, a_tok_valid, a_tok_dir, a_tok_value, a_tok_sat, a_tok_count, a_done, a_err} !== '0) begin
            n_fail++; $display("FAIL reset_a: got %h want 0", {a_rom_addr, a_tok_valid, a_tok_value, a_tok_count, a_done, a_err});
        end
        n_cmp++;
        if ({b_rom_addr, b_tok_valid, b_tok_value, b_tok_count, b_done, b_err} !== '0) begin
            n_fail++; $display("FAIL reset_b: got %h want 0", {b_rom_addr, b_tok_valid, b_tok_value, b_tok_count, b_done, b_err});
        end
    endtask

    task automatic test_basic();
        bit to;
        load_str("L68\nR48\n");
        start();
        drive(0, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL basic_timeout: got 1 want 0"); end
        n_cmp++;
        if (qa.size() != 2) begin n_fail++; $display("FAIL basic_ntok: got %0d want 2", qa.size()); end
        else begin
            n_cmp++;
            if (qa[0].dir !== 1'b0 || qa[0].value != 68 || qa[0].sat !== 1'b0) begin
                n_fail++; $display("FAIL basic_tok0: got %0d/%0d/%0d want 0/68/0", qa[0].dir, qa[0].value, qa[0].sat);
            end
            n_cmp++;
            if (qa[1].dir !== 1'b1 || qa[1].value != 48 || qa[1].sat !== 1'b0) begin
                n_fail++; $display("FAIL basic_tok1: got %0d/%0d/%0d want 1/48/0", qa[1].dir, qa[1].value, qa[1].sat);
            end
        end
        n_cmp++;
        if ({a_done, a_err} !== 2'b10) begin n_fail++; $display("FAIL basic_done_err: got %b want 10", {a_done, a_err}); end
        n_cmp++;
        if (a_tok_count !== 16'd2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", a_tok_count); end
        n_cmp++;
        if (a_rom_addr !== 17'd9) begin n_fail++; $display("FAIL basic_addr: got %0d want 9", a_rom_addr); end
    endtask

    task automatic test_backpressure();
        bit to;
        int cyc;
        load_str("L68\nR48\n");
        tok_ready = 1'b0;
        start();
        cyc = 0;
        while (!a_tok_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_cmp++; if (!a_tok_valid) begin n_fail++; $display("FAIL bp_wait_valid: got 0 want 1"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (a_tok_valid !== 1'b1 || a_tok_value !== 16'd68 || a_rom_addr !== 17'd4) begin
                n_fail++; $display("FAIL bp_stall%0d: got v=%b val=%0d addr=%0d want v=1 val=68 addr=4", k, a_tok_valid, a_tok_value, a_rom_addr);
            end
            @(posedge clk); #1;
        end
        drive(0, to);
        n_cmp++;
        if (to || qa.size() != 2) begin n_fail++; $display("FAIL bp_ntok: got %0d want 2", qa.size()); end
        else begin
            n_cmp++;
            if (qa[0].value != 68 || qa[1].value != 48 || qa[1].dir !== 1'b1) begin
                n_fail++; $display("FAIL bp_toks: got %0d,%0d want 68,48", qa[0].value, qa[1].value);
            end
        end
    endtask

    task automatic test_sat();
        bit to;
        load_str("R999\nL255\n");
        start();
        drive(0, to);
        n_cmp++;
        if (to || qb.size() != 2) begin n_fail++; $display("FAIL sat_ntok: got %0d want 2", qb.size()); end
        else begin
            n_cmp++;
            if (qb[0].dir !== 1'b1 || qb[0].value != 255 || qb[0].sat !== 1'b1) begin
                n_fail++; $display("FAIL sat_tok0: got %0d/%0d/%0d want 1/255/1", qb[0].dir, qb[0].value, qb[0].sat);
            end
            n_cmp++;
            if (qb[1].dir !== 1'b0 || qb[1].value != 255 || qb[1].sat !== 1'b0) begin
                n_fail++; $display("FAIL sat_tok1: got %0d/%0d/%0d want 0/255/0", qb[1].dir, qb[1].value, qb[1].sat);
            end
        end
        n_cmp++;
        if ({b_done, b_err} !== 2'b10) begin n_fail++; $display("FAIL sat_done: got %b want 10", {b_done, b_err}); end
        n_cmp++;
        if (qa.size() != 2 || qa[0].value != 999 || qa[0].sat !== 1'b0) begin
            n_fail++; $display("FAIL sat_wide: got n=%0d want 2 tokens, first 999 unsaturated", qa.size());
        end
    endtask

    task automatic test_crlf();
        bit to;
        load_str("L5\r\n\nR10\r\n");
        start();
        drive(0, to);
        n_cmp++;
        if (to || qa.size() != 2) begin n_fail++; $display("FAIL crlf_ntok: got %0d want 2", qa.size()); end
        else begin
            n_cmp++;
            if (qa[0].dir !== 1'b0 || qa[0].value != 5 || qa[1].dir !== 1'b1 || qa[1].value != 10) begin
                n_fail++; $display("FAIL crlf_toks: got %0d/%0d %0d/%0d want 0/5 1/10", qa[0].dir, qa[0].value, qa[1].dir, qa[1].value);
            end
        end
        n_cmp++;
        if (a_err !== 1'b0) begin n_fail++; $display("FAIL crlf_err: got %b want 0", a_err); end
    endtask

    task automatic test_errors();
        bit to;
        load_str("X5\n");
        start();
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_err, a_done} !== 2'b11 || a_rom_addr !== 17'd1) begin
            n_fail++; $display("FAIL err_first_byte: got err/done=%b addr=%0d want 11 addr=1", {a_err, a_done}, a_rom_addr);
        end
        drive(0, to);
        n_cmp++;
        if (qa.size() != 0 || a_tok_count !== 16'd0) begin n_fail++; $display("FAIL err_x_notok: got %0d want 0", qa.size()); end
        load_str("L\n");
        start();
        drive(0, to);
        n_cmp++;
        if (to || {a_err, a_done} !== 2'b11 || qa.size() != 0) begin
            n_fail++; $display("FAIL err_nodigit: got err/done=%b ntok=%0d want 11 0", {a_err, a_done}, qa.size());
        end
    endtask

    task automatic test_unterm();
        bit to;
        load_str("R7");
        start();
        drive(0, to);
        n_cmp++;
        if (to || qa.size() != 1) begin n_fail++; $display("FAIL unterm_ntok: got %0d want 1", qa.size()); end
        else begin
            n_cmp++;
            if (qa[0].dir !== 1'b1 || qa[0].value != 7) begin
                n_fail++; $display("FAIL unterm_tok: got %0d/%0d want 1/7", qa[0].dir, qa[0].value);
            end
        end
        n_cmp++;
        if ({a_done, a_err} !== 2'b10 || a_rom_addr !== 17'd3) begin
            n_fail++; $display("FAIL unterm_end: got done/err=%b addr=%0d want 10 addr=3", {a_done, a_err}, a_rom_addr);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        load_str("R12\n");
        start();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_rom_addr, a_tok_valid, a_tok_value, a_tok_count, a_done, a_err} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got addr=%0d v=%b done=%b want all zero", a_rom_addr, a_tok_valid, a_done);
        end
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, to);
        n_cmp++;
        if (to || qa.size() != 1) begin n_fail++; $display("FAIL rstmid_ntok: got %0d want 1", qa.size()); end
        else begin
            n_cmp++;
            if (qa[0].dir !== 1'b1 || qa[0].value != 12 || a_tok_count !== 16'd1) begin
                n_fail++; $display("FAIL rstmid_tok: got %0d/%0d cnt=%0d want 1/12 cnt=1", qa[0].dir, qa[0].value, a_tok_count);
            end
        end
    endtask

    function automatic void put(input logic [7:0] c);
        if (wl < 250) begin mem[wl] = c; wl++; end
    endfunction

    task automatic test_random();
        bit to;
        int nl, nd;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            wl = 0;
            nl = $urandom_range(1, 6);
            for (int l = 0; l < nl; l++) begin
                if ($urandom_range(0, 5) == 0) put(8'h0A);
                put($urandom_range(0, 1) ? "R" : "L");
                nd = $urandom_range(1, 6);
                if ($urandom_range(0, 24) == 0) nd = 0;
                for (int d = 0; d < nd; d++) put(8'h30 + 8'($urandom_range(0, 9)));
                if ($urandom_range(0, 29) == 0) put("X");
                if ($urandom_range(0, 3) == 0) put(8'h0D);
                if (l != nl - 1 || $urandom_range(0, 3) != 0) put(8'h0A);
            end
            start();
            drive(1, to);
            n_cmp++; if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: got 1 want 0", it); end
            model(16, 256, 131071);
            n_cmp++;
            if (qa.size() != mq.size()) begin n_fail++; $display("FAIL rnd%0d_a_ntok: got %0d want %0d", it, qa.size(), mq.size()); end
            else for (int t = 0; t < mq.size(); t++) begin
                n_cmp++;
                if (qa[t].dir !== mq[t].dir || qa[t].value != mq[t].value || qa[t].sat !== mq[t].sat) begin
                    n_fail++; $display("FAIL rnd%0d_a_tok%0d: got %0d/%0d/%0d want %0d/%0d/%0d", it, t, qa[t].dir, qa[t].value, qa[t].sat, mq[t].dir, mq[t].value, mq[t].sat);
                end
            end
            n_cmp++;
            if (a_err !== m_err || a_done !== 1'b1 || a_rom_addr != 17'(m_addr) || a_tok_count != 16'(mq.size())) begin
                n_fail++; $display("FAIL rnd%0d_a_end: got err=%b addr=%0d cnt=%0d want err=%b addr=%0d cnt=%0d", it, a_err, a_rom_addr, a_tok_count, m_err, m_addr, mq.size());
            end
            model(8, 16, 15);
            n_cmp++;
            if (qb.size() != mq.size()) begin n_fail++; $display("FAIL rnd%0d_b_ntok: got %0d want %0d", it, qb.size(), mq.size()); end
            else for (int t = 0; t < mq.size(); t++) begin
                n_cmp++;
                if (qb[t].dir !== mq[t].dir || qb[t].value != mq[t].value || qb[t].sat !== mq[t].sat) begin
                    n_fail++; $display("FAIL rnd%0d_b_tok%0d: got %0d/%0d/%0d want %0d/%0d/%0d", it, t, qb[t].dir, qb[t].value, qb[t].sat, mq[t].dir, mq[t].value, mq[t].sat);
                end
            end
            n_cmp++;
            if (b_err !== m_err || b_done !== 1'b1 || b_rom_addr != 4'(m_addr) || b_tok_count != 16'(mq.size())) begin
                n_fail++; $display("FAIL rnd%0d_b_end: got err=%b addr=%0d cnt=%0d want err=%b addr=%0d cnt=%0d", it, b_err, b_rom_addr, b_tok_count, m_err, m_addr, mq.size());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_sat();
        test_crlf();
        test_errors();
        test_unterm();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/day01_rotation_parser.md
Name: day01_rotation_parser

Overview:
- Downstream consumer of the day01 byte ROM: drives the ROM address and parses the ASCII rotation list (lines such as "L68", "R48") into tokens.
- Each token is a direction plus an unsigned decimal magnitude.
- Tokens go out on a valid/ready stream to the dial-solver stage.
- Owns the end-of-input and format-error detection for the day01 datapath.

Parameters:
- N_ADDR_BITS, 16: ROM address parameter; the address bus is N_ADDR_BITS+1 bits wide, matching the ROM.
- VALUE_W, 16: width of the parsed magnitude.
- COUNT_W, 16: width of the emitted-token counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- rom_addr  out  N_ADDR_BITS+1  byte address presented to the ROM.
- rom_data  in  8  ROM byte at rom_addr (ROM updates it on negedge).
- rom_valid  in  1  ROM byte is non-null.
- tok_valid  out  1  token available.
- tok_ready  in  1  downstream accepts the token.
- tok_dir  out  1  0 = 'L', 1 = 'R'.
- tok_value  out  VALUE_W  parsed magnitude.
- tok_sat  out  1  magnitude saturated (overflowed VALUE_W).
- tok_count  out  COUNT_W  tokens accepted so far; saturates at all-ones.
- done  out  1  sticky; input fully consumed or parse aborted.
- err  out  1  sticky; format error seen.

Behaviour:
- Reset values (async on rst_n low): rom_addr=0, tok_valid=0, tok_dir=0, tok_value=0, tok_sat=0, tok_count=0, done=0, err=0; state=S_DIR, accumulator=0, digit count=0, pending_end=0.
- Fetch timing:
  - rom_addr is registered. The ROM returns the byte for it on the following negedge; the parser samples rom_data/rom_valid on the next posedge.
  - In S_DIR and S_NUM, exactly one byte is consumed per cycle and rom_addr increments by 1.
  - rom_addr never wraps. Consuming the byte at the all-ones address also sets pending_end (end of input).
- S_DIR:
  - 'L'/'R': latch dir; clear accumulator, digit count and sat; go to S_NUM.
  - '\n' or '\r': skip (blank lines allowed).
  - rom_valid=0: go to S_DONE.
  - Any other byte: err=1, go to S_DONE.
- S_NUM:
  - '0'-'9': acc = acc*10 + digit, computed at VALUE_W+4 bits. If the result exceeds 2^VALUE_W-1, acc=all-ones and sat=1; sat stays set for the rest of the token. Digit count increments.
  - '\r': ignored.
  - '\n': if digit count = 0, err=1 and go to S_DONE. Otherwise load tok_value/tok_dir/tok_sat, tok_valid=1, go to S_EMIT.
  - rom_valid=0 with digit count > 0: emit the token as for '\n', set pending_end.
  - rom_valid=0 with digit count = 0: err=1, go to S_DONE.
  - Any other byte: err=1, go to S_DONE.
  - pending_end raised by the last-address rule is handled the same way as rom_valid=0.
- S_EMIT:
  - No fetch; rom_addr holds.
  - tok_valid and the tok_* outputs stay stable until tok_valid&&tok_ready is sampled.
  - On acceptance: tok_valid=0 and tok_count+1 (saturating) on that edge. Next state is S_DONE if pending_end, else S_DIR.
  - Latency: terminator consumed at edge k gives tok_valid high after edge k. With ready high at k+1 the token is accepted, and the next byte is fetched at edge k+2.
- S_DONE:
  - Terminal; done=1.
  - rom_addr frozen; tok_valid=0.
  - Only rst_n leaves this state.
- A reset asserted mid-token or mid-handshake discards the partial token with no emission; the parse restarts at address 0.
- err implies done. done without err means a clean end of input.

Test Plan:
- "L68\nR48\n\0", tok_ready=1 → tokens (0,68) then (1,48), each tok_sat=0; done=1, err=0, tok_count=2, final rom_addr=9.
- Same input with tok_ready held 0 for 5 cycles after the first tok_valid → tok_valid and tok_value=68 stable for all 5 cycles; rom_addr unchanged; both tokens delivered once ready rises.
- VALUE_W=8, "R999\nL255\n\0" → (1,255,sat=1), then (0,255,sat=0); done=1.
- "L5\r\n\nR10\r\n\0" → exactly two tokens, (0,5) and (1,10); err=0.
- "X5\n\0" → no token, err=1, done=1 after the first byte; "L\n" → err=1 with no token.
- Unterminated input "R7\0" → token (1,7) then done=1. Separately, rst_n pulsed low while "R12" is being parsed → all outputs return to reset values and the parse restarts from address 0.
